md_stall_controller: RTL and testbench
======================================

// Module: md_stall_controller
// PURPOSE
//  Sequences the multi-cycle multiply/divide unit of the 5-stage MIPS pipeline.
//  Decodes the E-stage instruction to launch mult/multu/div/divu and counts the
//  unit's latency.
//  Decodes the D-stage instruction and raises a stall for any HI/LO-class
//  instruction while the unit is launching or busy. Sits beside the forwarding
//  and stall logic; stall_md is ORed into the global D-stage stall.
// PARAMETERS
//  MULT_LAT  5   busy cycles for mult/multu (range 1..15)
//  DIV_LAT   10  busy cycles for div/divu (range 1..15)
// PORTS
//  clk       in   1   pipeline clock, rising edge
//  reset     in   1   asynchronous, active-high reset
//  instr_D   in   32  instruction in the ID stage
//  instr_E   in   32  instruction in the EX stage (bubble = 32'h0)
//  flush     in   1   exception/interrupt flush of the pipeline
//  md_start  out  1   one-cycle launch strobe to the MD unit (combinational)
//  md_op     out  2   operation: 00 mult, 01 multu, 10 div, 11 divu
//  md_busy   out  1   MD unit is computing (registered)
//  md_done   out  1   last busy cycle; HI/LO written at the end of this cycle
//  stall_md  out  1   freeze PC/IF-ID and insert a bubble into ID-EX
// BEHAVIOUR
//  Decode: op = instr[31:26] = 0 (R-type); funct = instr[5:0]:
//   24 mult, 25 multu, 26 div, 27 divu form the start class.
//   16 mfhi, 17 mthi, 18 mflo, 19 mtlo plus the start class form the HI/LO class.
//  State: 4-bit down counter cnt; IDLE when cnt==0, BUSY otherwise.
//  md_start = instr_E in start class & (cnt==0) & ~flush.
//  md_op = instr_E[1:0] whenever instr_E is in the start class, otherwise 2'b00.
//  Counter updates:
//   - md_start in cycle T: cnt <= MULT_LAT for funct 24/25, DIV_LAT for 26/27.
//   - else if cnt!=0: cnt <= cnt-1.
//  md_busy = (cnt!=0): high T+1..T+LAT.
//  md_done = (cnt==1): pulses in cycle T+LAT.
//  Result: at T+LAT+1 the unit is IDLE and mfhi/mflo in D is not stalled.
//  stall_md = instr_D in HI/LO class & (md_start | md_busy). Stall applies in
//   cycles T..T+LAT, i.e. LAT+1 cycles for a dependent instruction right behind.
//  Start while busy is a protocol violation (stall_md prevents it). md_start
//   stays 0 and the counter is not reloaded.
//  Back-to-back ops (mult then div): div stalls in D until T+LAT. It enters E
//   once the unit is idle and starts then.
//  reset (async): cnt <= 0 immediately. All outputs go to 0: md_start,
//   md_busy, md_done, stall_md, md_op = 00. This includes reset during BUSY.
//   Operation resumes on the first edge after release.
//  flush: always suppresses md_start in the same cycle. Its effect on an
//   in-flight operation depends on CONFIGURATION.
// CONFIGURATION
//  MD_CANCEL_EN defined: flush=1 with cnt!=0 clears cnt to 0 on the next edge.
//   md_done does not pulse and HI/LO keep their old value (the unit is told via
//   md_busy falling without md_done). flush has priority over decrement.
//  MD_CANCEL_EN undefined: flush does not touch cnt. An in-flight operation
//   runs to completion and md_done pulses at T+LAT as normal.
// TESTING
//  1 Reset: assert reset mid-cycle with cnt=7 -> all outputs 0 with no clock
//    edge; after release, cnt stays 0.
//  2 Mult, defaults: instr_E=mult(funct 24) at T -> md_start=1 and md_op=00 at T;
//    md_busy=1 T+1..T+5; md_done=1 only at T+5; idle at T+6.
//  3 Div + dependent mflo: instr_E=div, instr_D=mflo at T -> stall_md=1 T..T+10
//    (11 cycles); 0 at T+11; md_op=10.
//  4 Non-HI/LO in D while busy: instr_D=addu(funct 33) during busy -> stall_md=0.
//    A jr (funct 8) in D behaves the same.
//  5 Back-to-back: multu at T, divu held in D -> stall T..T+5. divu starts at
//    T+6 with md_op=11; md_done at T+16.
//  6 Flush at T+3 of div: with MD_CANCEL_EN, md_busy=0 from T+4 and no md_done.
//    Without it, md_done still pulses at T+10. Also: flush with a start-class
//    instr_E gives md_start=0.

Source files
------------

// File: rtl/md_stall_controller.sv
// Multiply/divide launch sequencer and HI/LO hazard stall for the 5-stage pipeline.
// Define MD_CANCEL_EN to let a pipeline flush cancel an in-flight MD operation.
module md_stall_controller #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  input  logic [31:0] instr_E,
  input  logic        flush,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic        md_busy,
  output logic        md_done,
  output logic        stall_md
);

  localparam logic [3:0] MultLat = 4'(MULT_LAT);
  localparam logic [3:0] DivLat  = 4'(DIV_LAT);

  logic [3:0] cnt_q, cnt_d;
  logic       e_start_class;
  logic       d_hilo_class;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_D[25:6], instr_D[1:0], instr_E[25:6]};

  // funct 24..27 is 0110xx; funct 16..19 is 0100xx.
  always_comb begin
    e_start_class = (instr_E[31:26] == 6'd0) && (instr_E[5:2] == 4'b0110);
    d_hilo_class  = (instr_D[31:26] == 6'd0) &&
                    ((instr_D[5:2] == 4'b0110) || (instr_D[5:2] == 4'b0100));
  end

  // Combinational outputs are masked by reset so they drop without a clock edge.
  always_comb begin
    md_busy  = (cnt_q != 4'd0);
    md_done  = (cnt_q == 4'd1);
    md_start = e_start_class && (cnt_q == 4'd0) && !flush && !reset;
    md_op    = (e_start_class && !reset) ? instr_E[1:0] : 2'b00;
    stall_md = d_hilo_class && (md_start || md_busy) && !reset;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (md_start) begin
      cnt_d = instr_E[1] ? DivLat : MultLat;
    end else if (cnt_q != 4'd0) begin
`ifdef MD_CANCEL_EN
      cnt_d = flush ? 4'd0 : cnt_q - 4'd1;
`else
      cnt_d = cnt_q - 4'd1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_md_stall_controller.sv
// Directed self-checking bench for md_stall_controller (default latencies 5/10).
module tb_md_stall_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_D;
  logic [31:0] instr_E;
  logic        flush;
  logic        md_start;
  logic [1:0]  md_op;
  logic        md_busy;
  logic        md_done;
  logic        stall_md;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  md_stall_controller #(
    .MULT_LAT(5),
    .DIV_LAT (10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .instr_D (instr_D),
    .instr_E (instr_E),
    .flush   (flush),
    .md_start(md_start),
    .md_op   (md_op),
    .md_busy (md_busy),
    .md_done (md_done),
    .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] funct);
    return {6'd0, 5'd8, 5'd9, 5'd10, 5'd0, funct};
  endfunction

  localparam logic [31:0] Nop   = 32'h0;
  localparam logic [31:0] Jr    = 32'h03e0_0008;
  logic [31:0] mult_i, multu_i, div_i, divu_i, mfhi_i, mflo_i, addu_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic start, input logic [1:0] op,
                            input logic busy, input logic done, input logic stall);
    check({tag, " md_start"}, 32'(md_start), 32'(start));
    check({tag, " md_op"},    32'(md_op),    32'(op));
    check({tag, " md_busy"},  32'(md_busy),  32'(busy));
    check({tag, " md_done"},  32'(md_done),  32'(done));
    check({tag, " stall_md"}, 32'(stall_md), 32'(stall));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] e, input logic [31:0] d, input logic f);
    instr_E = e;
    instr_D = d;
    flush   = f;
    #1;
  endtask

  initial begin
    mult_i  = rtype(6'd24);
    multu_i = rtype(6'd25);
    div_i   = rtype(6'd26);
    divu_i  = rtype(6'd27);
    mfhi_i  = rtype(6'd16);
    mflo_i  = rtype(6'd18);
    addu_i  = rtype(6'd33);

    // Power-on reset with a start-class instr in E: everything masked.
    reset = 1'b1;
    drive(div_i, mflo_i, 1'b0);
    check_outs("por", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(Nop, Nop, 1'b0);

    // 1: reset mid-cycle while cnt==7.
    next_cycle();
    drive(div_i, Nop, 1'b0);
    check_outs("rst T", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      drive(Nop, Nop, 1'b0);
    end
    check_outs("rst cnt7", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    drive(div_i, mflo_i, 1'b0);
    reset = 1'b1;
    #1;
    check_outs("rst async", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(Nop, Nop, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      drive(Nop, Nop, 1'b0);
      check_outs($sformatf("rst post%0d", k), 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    end

    // 2: mult, default latency.
    next_cycle();
    drive(mult_i, Nop, 1'b0);
    check_outs("mult T", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      drive(Nop, Nop, 1'b0);
      check_outs($sformatf("mult T+%0d", k), 1'b0, 2'b00, k <= 5, k == 5, 1'b0);
    end

    // 3: div with dependent mflo held in D.
    next_cycle();
    drive(div_i, mflo_i, 1'b0);
    check_outs("div T", 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      next_cycle();
      drive(Nop, mflo_i, 1'b0);
      check_outs($sformatf("div T+%0d", k), 1'b0, 2'b00, k <= 10, k == 10, k <= 10);
    end

    // 4: non-HI/LO in D while busy; start-while-busy must not reload.
    next_cycle();
    drive(mult_i, Nop, 1'b0);
    check_outs("nohl T", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(Nop, addu_i, 1'b0);
    check_outs("nohl addu", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(divu_i, Jr, 1'b0);
    check_outs("nohl jr", 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
    for (int k = 3; k <= 6; k++) begin
      next_cycle();
      drive(addu_i, addu_i, 1'b0);
      check_outs($sformatf("nohl T+%0d", k), 1'b0, 2'b00, k <= 5, k == 5, 1'b0);
    end

    // 5: back-to-back multu then divu.
    next_cycle();
    drive(multu_i, divu_i, 1'b0);
    check_outs("b2b T", 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      drive(Nop, divu_i, 1'b0);
      check_outs($sformatf("b2b T+%0d", k), 1'b0, 2'b00, 1'b1, k == 5, 1'b1);
    end
    next_cycle();
    drive(divu_i, Nop, 1'b0);
    check_outs("b2b T+6", 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    for (int k = 7; k <= 17; k++) begin
      next_cycle();
      drive(Nop, Nop, 1'b0);
      check_outs($sformatf("b2b T+%0d", k), 1'b0, 2'b00, k <= 16, k == 16, 1'b0);
    end

    // 6: flush at T+3 of a div.
    next_cycle();
    drive(div_i, Nop, 1'b0);
    check_outs("fl T", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      drive(Nop, Nop, 1'b0);
      check_outs($sformatf("fl T+%0d", k), 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    end
    next_cycle();
    drive(Nop, mfhi_i, 1'b1);
    check_outs("fl T+3", 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    for (int k = 4; k <= 11; k++) begin
      next_cycle();
      drive(Nop, mfhi_i, 1'b0);
`ifdef MD_CANCEL_EN
      check_outs($sformatf("fl T+%0d", k), 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
`else
      check_outs($sformatf("fl T+%0d", k), 1'b0, 2'b00, k <= 10, k == 10, k <= 10);
`endif
    end

    // Flush suppresses a launch; md_op still decodes.
    next_cycle();
    drive(divu_i, Nop, 1'b1);
    check_outs("fl start", 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(Nop, Nop, 1'b0);
    check_outs("fl start+1", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
